// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment excess-3 reader: digit segment
// patterns (active-high, bit6=a ... bit0=g), blank pattern, excess-3 offset
// and the stability FSM state type.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [3:0] EXCESS3_OFFSET = 4'd3;

   typedef enum logic {
      SETTLE = 1'b0,
      LOCKED = 1'b1
   } state_t;

endpackage

// File: rtl/seg7_to_excess3.sv
// Combinational lookup from an active-low segment bus to an excess-3 code.
// Blank and unrecognised patterns both give code 0, flagged separately.
module seg7_to_excess3
   import seg7_pkg::*;
(
   input  logic [6:0] seg_n,
   output logic [3:0] code,
   output logic       blank,
   output logic       err
);

   logic [6:0] seg;

   assign seg = ~seg_n;

   // Pattern match: digits map to digit+3, all-off is blank, the rest is error.
   always_comb begin
      code  = 4'd0;
      blank = 1'b0;
      err   = 1'b0;
      case (seg)
         SEG_0:     code = EXCESS3_OFFSET + 4'd0;
         SEG_1:     code = EXCESS3_OFFSET + 4'd1;
         SEG_2:     code = EXCESS3_OFFSET + 4'd2;
         SEG_3:     code = EXCESS3_OFFSET + 4'd3;
         SEG_4:     code = EXCESS3_OFFSET + 4'd4;
         SEG_5:     code = EXCESS3_OFFSET + 4'd5;
         SEG_6:     code = EXCESS3_OFFSET + 4'd6;
         SEG_7:     code = EXCESS3_OFFSET + 4'd7;
         SEG_8:     code = EXCESS3_OFFSET + 4'd8;
         SEG_9:     code = EXCESS3_OFFSET + 4'd9;
         SEG_BLANK: blank = 1'b1;
         default:   err = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_excess3_reader.sv
// Debounced seven-segment reader. A pattern must be held STABLE_CYCLES
// consecutive samples before it is reported; a report is made only when the
// stable pattern differs from the previously reported one (or is the first
// since reset).
//
// Output handshake: out_valid/out_code/out_blank/out_err form one result.
// A result transfers on a rising edge where out_valid=1 and out_ready=1.
// While out_valid=1 and out_ready=0 the result is held unchanged. A new
// report on a transfer edge replaces the result and keeps out_valid high; a
// report arriving while a result is stalled is dropped and sets the sticky
// overrun flag without updating the last-reported pattern.
module seg7_excess3_reader
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg_n,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [3:0] out_code,
   output logic       out_blank,
   output logic       out_err,
   output logic       overrun,
   output state_t     fsm_state
);

   localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

   logic [6:0] samp;
   logic [6:0] last_pat;
   logic [3:0] cnt;
   logic [3:0] cnt_next;
   logic       first;
   state_t     state;
   state_t     state_next;

   logic [3:0] dec_code;
   logic       dec_blank;
   logic       dec_err;

   logic       same;
   logic       stable_event;
   logic       report;
   logic       load;
   logic       drop;

   seg7_to_excess3 u_lookup (
      .seg_n (seg_n),
      .code  (dec_code),
      .blank (dec_blank),
      .err   (dec_err)
   );

   assign fsm_state = state;

   // Stability counter, FSM next state and report/handshake decisions.
   always_comb begin
      same         = (seg_n == samp);
      cnt_next     = cnt;
      state_next   = state;
      stable_event = 1'b0;

      if (!same) begin
         cnt_next = 4'd1;
      end else if (cnt >= CNT_MAX) begin
         cnt_next = CNT_MAX;
      end else begin
         cnt_next = cnt + 4'd1;
      end

      case (state)
         SETTLE: begin
            if (cnt_next == CNT_MAX) begin
               stable_event = 1'b1;
               state_next   = LOCKED;
            end
         end
         LOCKED: begin
            if (!same) begin
               state_next = SETTLE;
            end
         end
         default: state_next = SETTLE;
      endcase

      report = stable_event && (first || (seg_n != last_pat));
      load   = report && (!out_valid || out_ready);
      drop   = report && out_valid && !out_ready;
   end

   // State register, sample/counter pipeline and output result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SETTLE;
         cnt       <= 4'd0;
         samp      <= 7'h7F;
         last_pat  <= 7'h7F;
         first     <= 1'b1;
         out_valid <= 1'b0;
         out_code  <= 4'd0;
         out_blank <= 1'b0;
         out_err   <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         samp  <= seg_n;
         if (load) begin
            out_valid <= 1'b1;
            out_code  <= dec_code;
            out_blank <= dec_blank;
            out_err   <= dec_err;
            last_pat  <= seg_n;
            first     <= 1'b0;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (drop) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg7_excess3_reader.sv
// Bench for seg7_excess3_reader: directed scenarios plus a randomized run,
// all checked against a history-based reference model.
module tb_seg7_excess3_reader;
   import seg7_pkg::*;

   localparam int S = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] seg_n = 7'h7F;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [3:0] out_code;
   logic       out_blank;
   logic       out_err;
   logic       overrun;
   state_t     fsm_state;

   int vectors = 0;
   int miscompares = 0;

   seg7_excess3_reader #(.STABLE_CYCLES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .seg_n     (seg_n),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_code  (out_code),
      .out_blank (out_blank),
      .out_err   (out_err),
      .overrun   (overrun),
      .fsm_state (fsm_state)
   );

   // clock
   always #5 clk = ~clk;

   // reference model state
   logic [6:0] hist[$];
   logic       m_valid, m_blank, m_err, m_ovr, m_first;
   logic [3:0] m_code;
   logic [6:0] m_last;
   logic [6:0] digit_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                  7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                  7'b1111111, 7'b1111011};

   // reference decode from the digit table (active-high patterns)
   function automatic void ref_decode(input logic [6:0] sn, output logic [3:0] code,
                                      output logic blank, output logic err);
      logic [6:0] act;
      act   = ~sn;
      code  = 4'd0;
      blank = (act == 7'd0);
      err   = !blank;
      for (int i = 0; i < 10; i++) begin
         if (act == digit_tab[i]) begin
            code = 4'(i + 3);
            err  = 1'b0;
         end
      end
   endfunction

   // the newest sample completes a run of exactly S identical samples
   function automatic logic stable_now();
      int n;
      n = hist.size();
      if (n < S) return 1'b0;
      for (int i = 1; i < S; i++)
         if (hist[n-1-i] !== hist[n-1]) return 1'b0;
      return (n == S) || (hist[n-1-S] !== hist[n-1]);
   endfunction

   function automatic logic [8:0] exp_vec();
      return {m_valid, m_ovr, m_valid ? {m_code, m_blank, m_err} : 6'd0};
   endfunction

   function automatic logic [8:0] obs_vec();
      return {out_valid, overrun, m_valid ? {out_code, out_blank, out_err} : 6'd0};
   endfunction

   // drive one clock of stimulus, advance the model, settle past the edge
   task automatic cycle(input logic [6:0] sn, input logic rdy, input logic r);
      logic       rep;
      logic [3:0] c;
      logic       b, e;
      seg_n     = sn;
      out_ready = rdy;
      rst       = r;
      @(posedge clk);
      if (r) begin
         hist.delete();
         m_valid = 0; m_code = 0; m_blank = 0; m_err = 0; m_ovr = 0;
         m_first = 1; m_last = 7'h7F;
      end else begin
         hist.push_back(sn);
         if (hist.size() > S + 1) void'(hist.pop_front());
         rep = stable_now() && (m_first || sn !== m_last);
         if (rep && m_valid && !rdy) begin
            m_ovr = 1;
         end else if (rep) begin
            ref_decode(sn, c, b, e);
            m_valid = 1; m_code = c; m_blank = b; m_err = e;
            m_last = sn; m_first = 0;
         end else if (m_valid && rdy) begin
            m_valid = 0;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      cycle(7'h7F, 1'b0, 1'b1);
      cycle(7'h7F, 1'b0, 1'b1);
      vectors++;
      if ({out_valid, out_code, out_blank, out_err, overrun} !== 8'd0 || fsm_state !== SETTLE) begin
         miscompares++;
         $display("FAIL reset: got v=%b c=%0d b=%b e=%b o=%b st=%0d, want all 0, SETTLE",
                  out_valid, out_code, out_blank, out_err, overrun, fsm_state);
      end
   endtask

   task automatic test_first_digit();
      cycle(7'h7F, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) begin
         cycle(~7'b1111110, 1'b1, 1'b0);
         vectors++;
         if (out_valid !== (i == 3)) begin
            miscompares++;
            $display("FAIL first_digit_latency edge %0d: got v=%b want %b", i + 1, out_valid, (i == 3));
         end
         if (i == 3) begin
            vectors++;
            if (out_code !== 4'd3) begin
               miscompares++;
               $display("FAIL first_digit_code: got %0d want 3", out_code);
            end
         end
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL first_digit_model edge %0d: got %h want %h", i + 1, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_short_pattern();
      int n_valid;
      logic [3:0] seen;
      n_valid = 0;
      seen = 0;
      cycle(7'h7F, 1'b1, 1'b1);
      for (int i = 0; i < 12; i++) begin
         cycle((i < 3) ? ~7'b1111011 : ~7'b0110000, 1'b1, 1'b0);
         if (out_valid) begin n_valid++; seen = out_code; end
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL short_pattern_model edge %0d: got %h want %h", i + 1, obs_vec(), exp_vec());
         end
      end
      vectors++;
      if (n_valid != 1 || seen !== 4'd4) begin
         miscompares++;
         $display("FAIL short_pattern_reports: got %0d reports last code %0d, want 1 report code 4", n_valid, seen);
      end
   endtask

   task automatic test_overrun();
      cycle(7'h7F, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) begin
         cycle((i < 6) ? ~7'b1011011 : ~7'b1111111, 1'b0, 1'b0);
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL overrun_model edge %0d: got %h want %h", i + 1, obs_vec(), exp_vec());
         end
      end
      vectors++;
      if ({out_valid, out_code, overrun} !== {1'b1, 4'd8, 1'b1}) begin
         miscompares++;
         $display("FAIL overrun_held: got v=%b c=%0d o=%b want v=1 c=8 o=1", out_valid, out_code, overrun);
      end
      for (int i = 0; i < 6; i++) begin
         cycle(~7'b1111111, 1'b1, 1'b0);
         vectors++;
         if (out_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL overrun_drain edge %0d: got v=%b %h want v=0 %h", i, out_valid, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_blank_err();
      logic got_blank, got_err;
      got_blank = 0;
      got_err = 0;
      cycle(7'h7F, 1'b1, 1'b1);
      for (int i = 0; i < 14; i++) begin
         cycle((i < 6) ? 7'h7F : ~7'b1000001, 1'b1, 1'b0);
         if (out_valid && out_blank && !out_err && out_code == 4'd0) got_blank = 1;
         if (out_valid && out_err && !out_blank && out_code == 4'd0) got_err = 1;
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL blank_err_model edge %0d: got %h want %h", i + 1, obs_vec(), exp_vec());
         end
      end
      vectors++;
      if (!got_blank || !got_err) begin
         miscompares++;
         $display("FAIL blank_err_seen: got blank=%b err=%b want 1 1", got_blank, got_err);
      end
   endtask

   task automatic test_glitch_and_reset();
      int n_valid;
      cycle(7'h7F, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) cycle(~7'b1111001, 1'b1, 1'b0);
      n_valid = 0;
      for (int i = 0; i < 12; i++) begin
         cycle((i < 2) ? 7'h00 : ~7'b1111001, 1'b1, 1'b0);
         if (out_valid) n_valid++;
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL glitch_model edge %0d: got %h want %h", i + 1, obs_vec(), exp_vec());
         end
      end
      vectors++;
      if (n_valid != 0) begin
         miscompares++;
         $display("FAIL glitch_no_report: got %0d reports want 0", n_valid);
      end
      for (int i = 0; i < 5; i++) cycle(~7'b0110011, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(~7'b1110000, 1'b0, 1'b0);
      vectors++;
      if ({out_valid, overrun} !== 2'b11) begin
         miscompares++;
         $display("FAIL pre_reset_pending: got v=%b o=%b want 1 1", out_valid, overrun);
      end
      cycle(~7'b1110000, 1'b0, 1'b1);
      vectors++;
      if ({out_valid, overrun} !== 2'b00) begin
         miscompares++;
         $display("FAIL mid_reset: got v=%b o=%b want 0 0", out_valid, overrun);
      end
   endtask

   task automatic test_random();
      logic [6:0] pat;
      int len;
      cycle(7'h7F, 1'b1, 1'b1);
      for (int k = 0; k < 120; k++) begin
         case ($urandom_range(0, 3))
            0, 1:    pat = ~digit_tab[$urandom_range(0, 9)];
            2:       pat = 7'h7F;
            default: pat = 7'($urandom_range(0, 127));
         endcase
         len = $urandom_range(1, 7);
         for (int j = 0; j < len; j++) begin
            cycle(pat, ($urandom_range(0, 3) != 0), 1'b0);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
               miscompares++;
               $display("FAIL random_model step %0d: got %h want %h", k, obs_vec(), exp_vec());
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_digit();
      test_short_pattern();
      test_overrun();
      test_blank_err();
      test_glitch_and_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
